// File: rtl/riscv_hwloop_pkg.sv
// Shared types for the hardware-loop unit: register-field selector and the
// architectural loop-set layout at the default 32-bit widths.
package riscv_hwloop_pkg;

  localparam int HWLP_DEF_AW = 32;
  localparam int HWLP_DEF_CW = 32;

  typedef enum logic [1:0] {
    HWLP_START = 2'd0,
    HWLP_END   = 2'd1,
    HWLP_CNT   = 2'd2
  } hwlp_wsel_e;

  typedef struct packed {
    logic [HWLP_DEF_AW-1:0] start_addr;
    logic [HWLP_DEF_AW-1:0] end_addr;
    logic [HWLP_DEF_CW-1:0] cnt;
  } hwlp_set_t;

endpackage

// File: rtl/riscv_hwloop_pending.sv
// Per-loop count of decrements that have been jumped on but not yet committed.
module riscv_hwloop_pending #(
  parameter  int MAX_INFLIGHT = 3,
  localparam int PW           = $clog2(MAX_INFLIGHT+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          flush_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [PW-1:0] pend_o,
  output logic          full_o
);

  logic [PW-1:0] pend_q, pend_d;

  assign full_o = (pend_q == PW'(MAX_INFLIGHT));
  assign pend_o = pend_q;

  // Inc and dec together cancel; both directions saturate.
  always_comb begin
    pend_d = pend_q;
    if (clr_i || flush_i)
      pend_d = '0;
    else if (inc_i && !dec_i && !full_o)
      pend_d = pend_q + PW'(1);
    else if (dec_i && !inc_i && (pend_q != '0))
      pend_d = pend_q - PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/riscv_hwloop_unit.sv
// Hardware-loop unit: loop register file, end-address match with in-flight
// aware exit check, and priority select of the innermost matching loop.
module riscv_hwloop_unit
  import riscv_hwloop_pkg::*;
#(
  parameter  int N_REGS       = 2,
  parameter  int ADDR_WIDTH   = 32,
  parameter  int CNT_WIDTH    = 32,
  parameter  int MAX_INFLIGHT = 3,
  localparam int IW           = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  localparam int PW           = $clog2(MAX_INFLIGHT+1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ADDR_WIDTH-1:0]               pc_i,
  input  logic                                pc_valid_i,
  input  logic                                we_i,
  input  logic [IW-1:0]                       waddr_i,
  input  logic [1:0]                          wsel_i,
  input  logic [31:0]                         wdata_i,
  input  logic                                jump_ack_i,
  input  logic [N_REGS-1:0]                   commit_i,
  input  logic                                flush_i,
  output logic                                hwlp_jump_o,
  output logic [ADDR_WIDTH-1:0]               hwlp_targ_addr_o,
  output logic                                hwlp_stall_o,
  output logic [N_REGS-1:0][ADDR_WIDTH-1:0]   start_o,
  output logic [N_REGS-1:0][ADDR_WIDTH-1:0]   end_o,
  output logic [N_REGS-1:0][CNT_WIDTH-1:0]    cnt_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic [CNT_WIDTH-1:0]  cnt;
  } loop_t;

  loop_t [N_REGS-1:0]          loop_q, loop_d;
  logic  [N_REGS-1:0][PW-1:0]  pend;
  logic  [N_REGS-1:0]          full, match, cnt_wr, inc;
  logic  [IW-1:0]              sel_idx;
  logic                        sel_vld;

  for (genvar g = 0; g < N_REGS; g++) begin : g_loop
    logic [CNT_WIDTH-1:0] eff;

    // Iterations left once every in-flight decrement retires.
    assign eff      = loop_q[g].cnt - CNT_WIDTH'(pend[g]);
    assign match[g] = pc_valid_i && (pc_i == loop_q[g].end_addr) && (eff >= CNT_WIDTH'(2));
    assign cnt_wr[g] = we_i && (wsel_i == HWLP_CNT) && (waddr_i == IW'(g));
    assign inc[g]   = jump_ack_i && hwlp_jump_o && (sel_idx == IW'(g));

    riscv_hwloop_pending #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_pend (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_wr[g]),
      .flush_i (flush_i),
      .inc_i   (inc[g]),
      .dec_i   (commit_i[g]),
      .pend_o  (pend[g]),
      .full_o  (full[g])
    );

    assign start_o[g] = loop_q[g].start_addr;
    assign end_o[g]   = loop_q[g].end_addr;
    assign cnt_o[g]   = loop_q[g].cnt;
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = N_REGS-1; i >= 0; i--) begin
      if (match[i]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // A saturated in-flight count turns the jump into a stall, never a fall-through.
  assign hwlp_jump_o      = sel_vld && !full[sel_idx];
  assign hwlp_stall_o     = sel_vld &&  full[sel_idx];
  assign hwlp_targ_addr_o = sel_vld ? loop_q[sel_idx].start_addr : '0;

  always_comb begin
    loop_d = loop_q;
    for (int i = 0; i < N_REGS; i++) begin
      if (we_i && (waddr_i == IW'(i))) begin
        case (wsel_i)
          HWLP_START: loop_d[i].start_addr = ADDR_WIDTH'(wdata_i);
          HWLP_END:   loop_d[i].end_addr   = ADDR_WIDTH'(wdata_i);
          HWLP_CNT:   loop_d[i].cnt        = CNT_WIDTH'(wdata_i);
          default: ;
        endcase
      end
      if (commit_i[i] && !cnt_wr[i] && (loop_q[i].cnt != '0))
        loop_d[i].cnt = loop_q[i].cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) loop_q <= '0;
    else     loop_q <= loop_d;
  end

endmodule
